apb_master: RTL and testbench

APB requester that drives the peripheral bus on behalf of a simple command/response interface (testbench, CPU stub or sequencer). It accepts one read or write command at a time and runs the APB SETUP and ACCESS phases. It waits for PREADY, with a bounded timeout, and returns read data and a status on a response channel. It is the initiator for our APB register slaves, such as the student-info register block at 0x0/0x4/0x8/0xC.

---
 rtl/apb_master.sv | 149 ++++++++++++++
 tb/tb_apb_master.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// rtl/apb_master.sv - APB requester: one command at a time through SETUP/ACCESS, with a bounded PREADY wait and a response channel.
module apb_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  busy,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY
);

    // A zero timeout still needs a one-bit counter so the widths stay legal.
    localparam int CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_MAX     = {CW{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t                state_q,     state_d;
    logic                  psel_q,      psel_d;
    logic                  penable_q,   penable_d;
    logic                  pwrite_q,    pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q,     paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q,    pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_error_q, rsp_error_d;
    logic [CW-1:0]         wait_cnt_q,  wait_cnt_d;
    logic [CW-1:0]         wait_cnt_inc;

    assign cmd_ready = PRESETn && (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;

    assign wait_cnt_inc = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        wait_cnt_d  = wait_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_d    = ST_SETUP;
                    psel_d     = 1'b1;
                    penable_d  = 1'b0;
                    pwrite_d   = cmd_write;
                    paddr_d    = cmd_addr;
                    pwdata_d   = cmd_wdata;
                    wait_cnt_d = '0;
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    state_d     = ST_RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b0;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                end else begin
                    wait_cnt_d = wait_cnt_inc;
                    if ((TIMEOUT_CYCLES != 0) && (wait_cnt_inc == TIMEOUT_VAL)) begin
                        state_d     = ST_RESP;
                        psel_d      = 1'b0;
                        penable_d   = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                        rsp_rdata_d = '0;
                    end
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q     <= ST_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - directed bench for apb_master against a small behavioural APB slave.
module tb_apb_master;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        busy;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    int checks   = 0;
    int failures = 0;

    // Slave knobs: wait states before PREADY, hard stall, and a PREADY forced outside transfers.
    int          wait_states = 0;
    logic        stall       = 1'b0;
    logic        spurious    = 1'b0;
    int          acnt        = 0;
    logic [31:0] mem [4];

    always #5 PCLK = ~PCLK;

    apb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .busy(busy),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    assign PREADY = spurious | (!stall && PSEL && PENABLE && (acnt >= wait_states));
    assign PRDATA = (PADDR[3:2] == 2'd2) ? 32'h49564E41 : mem[PADDR[3:2]];

    always @(posedge PCLK) begin
        if (PSEL && PENABLE && !PREADY) acnt <= acnt + 1;
        else acnt <= 0;
        if (PSEL && PENABLE && PREADY && PWRITE) mem[PADDR[3:2]] <= PWDATA;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge inside SETUP.
    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        check("cmd_ready_before_accept", {31'd0, cmd_ready}, 32'd1);
        @(posedge PCLK);
        @(negedge PCLK);
        cmd_valid = 1'b0;
    endtask

    initial begin
        PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b1;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_psel",      {31'd0, PSEL},      32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_paddr",     PADDR,              32'd0);
        PRESETn = 1'b1;
        @(negedge PCLK);

        // Write 7 to 0x4, zero-wait slave.
        send(1'b1, 32'h4, 32'h7);
        check("wr_setup_psel",    {31'd0, PSEL},    32'd1);
        check("wr_setup_penable", {31'd0, PENABLE}, 32'd0);
        check("wr_setup_paddr",   PADDR,            32'h4);
        check("wr_setup_pwrite",  {31'd0, PWRITE},  32'd1);
        check("wr_setup_pwdata",  PWDATA,           32'h7);
        check("wr_setup_busy",    {31'd0, busy},    32'd1);
        check("wr_setup_cmd_rdy", {31'd0, cmd_ready}, 32'd0);
        @(negedge PCLK);
        check("wr_access_penable", {31'd0, PENABLE}, 32'd1);
        @(negedge PCLK);
        check("wr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("wr_rsp_error", {31'd0, rsp_error}, 32'd0);
        check("wr_rsp_rdata", rsp_rdata,          32'd0);
        check("wr_rsp_psel",  {31'd0, PSEL},      32'd0);
        check("wr_paddr_kept", PADDR,             32'h4);
        @(negedge PCLK);
        check("wr_idle_valid", {31'd0, rsp_valid}, 32'd0);
        check("wr_idle_ready", {31'd0, cmd_ready}, 32'd1);

        // Read back 0x4; PWDATA carries cmd_wdata even for reads.
        send(1'b0, 32'h4, 32'hDEAD);
        check("rd_setup_pwrite", {31'd0, PWRITE}, 32'd0);
        check("rd_setup_pwdata", PWDATA,          32'hDEAD);
        @(negedge PCLK);
        @(negedge PCLK);
        check("rd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("rd_rsp_rdata", rsp_rdata,          32'h7);
        @(negedge PCLK);

        // Three wait states.
        wait_states = 3;
        send(1'b0, 32'h8, 32'h55);
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            check("ws_penable",   {31'd0, PENABLE},   32'd1);
            check("ws_psel",      {31'd0, PSEL},      32'd1);
            check("ws_paddr",     PADDR,              32'h8);
            check("ws_pwdata",    PWDATA,             32'h55);
            check("ws_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        end
        @(negedge PCLK);
        check("ws_pready_4th", {31'd0, PREADY}, 32'd1);
        @(negedge PCLK);
        check("ws_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("ws_rsp_rdata", rsp_rdata,          32'h49564E41);
        check("ws_rsp_error", {31'd0, rsp_error}, 32'd0);
        @(negedge PCLK);
        wait_states = 0;

        // Timeout after 16 ACCESS cycles with PREADY low.
        stall = 1'b1;
        send(1'b1, 32'hC, 32'h1234);
        for (int i = 0; i < 16; i++) begin
            @(negedge PCLK);
            check("to_access_penable", {31'd0, PENABLE}, 32'd1);
        end
        @(negedge PCLK);
        check("to_psel",      {31'd0, PSEL},      32'd0);
        check("to_penable",   {31'd0, PENABLE},   32'd0);
        check("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("to_rsp_error", {31'd0, rsp_error}, 32'd1);
        check("to_rsp_rdata", rsp_rdata,          32'd0);
        @(negedge PCLK);
        stall = 1'b0;
        send(1'b0, 32'h4, 32'h0);
        @(negedge PCLK);
        @(negedge PCLK);
        check("post_to_rdata", rsp_rdata,          32'h7);
        check("post_to_error", {31'd0, rsp_error}, 32'd0);
        @(negedge PCLK);

        // Response backpressure with a competing command pending.
        rsp_ready = 1'b0;
        send(1'b0, 32'h8, 32'h0);
        @(negedge PCLK);
        @(negedge PCLK);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0; cmd_wdata = 32'h99;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_rsp_rdata", rsp_rdata,          32'h49564E41);
            check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            check("bp_psel",      {31'd0, PSEL},      32'd0);
            @(negedge PCLK);
        end
        rsp_ready = 1'b1;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        check("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
        check("bp_release_ready", {31'd0, cmd_ready}, 32'd1);
        check("bp_release_busy",  {31'd0, busy},      32'd0);
        @(negedge PCLK);

        // Reset during ACCESS, then a stray PREADY pulse.
        stall = 1'b1;
        send(1'b1, 32'h0, 32'hAA);
        @(negedge PCLK);
        check("rm_access_penable", {31'd0, PENABLE}, 32'd1);
        PRESETn = 1'b0;
        @(negedge PCLK);
        check("rm_psel",      {31'd0, PSEL},      32'd0);
        check("rm_penable",   {31'd0, PENABLE},   32'd0);
        check("rm_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rm_busy",      {31'd0, busy},      32'd0);
        PRESETn = 1'b1; stall = 1'b0; spurious = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge PCLK);
            check("rm_pulse_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            check("rm_pulse_busy",      {31'd0, busy},      32'd0);
        end

        // Spurious PREADY in IDLE and SETUP.
        send(1'b0, 32'h8, 32'h0);
        check("sp_setup_psel",    {31'd0, PSEL},      32'd1);
        check("sp_setup_penable", {31'd0, PENABLE},   32'd0);
        check("sp_setup_rvalid",  {31'd0, rsp_valid}, 32'd0);
        spurious = 1'b0;
        @(negedge PCLK);
        check("sp_access_penable", {31'd0, PENABLE}, 32'd1);
        @(negedge PCLK);
        check("sp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("sp_rsp_rdata", rsp_rdata,          32'h49564E41);
        @(negedge PCLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
